// File: rtl/iris_argmax_if.sv
// Decision-stage port bundle: score input strobe, result handshake and status flags.
interface iris_argmax_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CLASSES = 3,
  parameter int CLASS_W     = $clog2(NUM_CLASSES)
);
  logic                              En;
  logic                              In_Valid;
  logic [NUM_CLASSES*DATA_WIDTH-1:0] Y_Bus;
  logic                              Out_Ready;
  logic                              Out_Valid;
  logic [CLASS_W-1:0]                Class;
  logic [DATA_WIDTH-1:0]             Max_Val;
  logic                              Tie;
  logic                              Busy;
  logic                              Overrun;

  modport master (
    output En, In_Valid, Y_Bus, Out_Ready,
    input  Out_Valid, Class, Max_Val, Tie, Busy, Overrun
  );

  modport slave (
    input  En, In_Valid, Y_Bus, Out_Ready,
    output Out_Valid, Class, Max_Val, Tie, Busy, Overrun
  );
endinterface

// File: rtl/iris_argmax.sv
// Argmax stage: captures NUM_CLASSES signed scores, scans one per En cycle; optional IRIS_ARGMAX_TIE_DETECT_EN drives Tie.
// Latency NUM_CLASSES-1 En cycles to Out_Valid; result held until Out_Ready; In_Valid while Busy is dropped and flags Overrun.
module iris_argmax #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CLASSES = 3,
  parameter int CLASS_W     = $clog2(NUM_CLASSES)
) (
  input logic          clk,
  input logic          rst,
  iris_argmax_if.slave bus
);
  localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] yr [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] best, best_nxt, cur, max_r;
  logic [CLASS_W-1:0]           idx, idx_nxt, cnt, class_r;
  logic                         out_valid, overrun, gt;
  logic                         start, step, last, accept, flush;

  assign cur      = yr[cnt];
  assign gt       = cur > best;
  assign best_nxt = gt ? cur : best;
  assign idx_nxt  = gt ? cnt : idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    accept    = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.En && bus.In_Valid) begin
          start     = 1'b1;
          state_nxt = COMPARE;
        end
      end
      COMPARE: begin
        if (bus.En) begin
          step = 1'b1;
          if (cnt == LAST_IDX) begin
            last      = 1'b1;
            state_nxt = OUTPUT;
          end
        end
      end
      OUTPUT: begin
        if (bus.En && out_valid && bus.Out_Ready) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        // Recover from a corrupted encoding without presenting a stale result
        flush     = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) yr[i] <= '0;
      best      <= '0;
      idx       <= '0;
      cnt       <= '0;
      class_r   <= '0;
      max_r     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (flush) out_valid <= 1'b0;
      if (bus.En) begin
        if (start) begin
          for (int i = 0; i < NUM_CLASSES; i++)
            yr[i] <= bus.Y_Bus[i*DATA_WIDTH +: DATA_WIDTH];
          best <= bus.Y_Bus[DATA_WIDTH-1:0];
          idx  <= '0;
          cnt  <= CLASS_W'(1);
        end
        if (step) begin
          best <= best_nxt;
          idx  <= idx_nxt;
          cnt  <= cnt + CLASS_W'(1);
        end
        if (last) begin
          class_r   <= idx_nxt;
          max_r     <= best_nxt;
          out_valid <= 1'b1;
        end
        if (accept) out_valid <= 1'b0;
        // Any strobe outside IDLE, including on the accepting edge, is lost
        if (bus.In_Valid && state != IDLE) overrun <= 1'b1;
      end
    end
  end

`ifdef IRIS_ARGMAX_TIE_DETECT_EN
  logic tie_r, tie_nxt, tie_o;

  always_comb begin
    tie_nxt = tie_r;
    if (gt)                tie_nxt = 1'b0;
    else if (cur == best)  tie_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tie_r <= 1'b0;
      tie_o <= 1'b0;
    end else if (bus.En) begin
      if (start)     tie_r <= 1'b0;
      else if (step) tie_r <= tie_nxt;
      if (last)      tie_o <= tie_nxt;
    end
  end

  assign bus.Tie = tie_o;
`else
  assign bus.Tie = 1'b0;
`endif

  assign bus.Out_Valid = out_valid;
  assign bus.Class     = class_r;
  assign bus.Max_Val   = max_r;
  assign bus.Busy      = (state != IDLE);
  assign bus.Overrun   = overrun;
endmodule

// File: tb/tb_iris_argmax.sv
// Scoreboarded bench for iris_argmax: directed corner cases plus randomized score sets.
module tb_iris_argmax;
  localparam int DW = 8;
  localparam int NC = 3;
  localparam int CW = $clog2(NC);

  typedef struct {
    int cls;
    int mx;
    int tie;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  iris_argmax_if #(.DATA_WIDTH(DW), .NUM_CLASSES(NC)) bus_if ();

  iris_argmax #(.DATA_WIDTH(DW), .NUM_CLASSES(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  function automatic logic [NC*DW-1:0] pack(input int y0, input int y1, input int y2);
    logic [7:0] a, b, c;
    a = y0[7:0];
    b = y1[7:0];
    c = y2[7:0];
    return {c, b, a};
  endfunction

  // Reference: find the maximum first, then the lowest index holding it
  function automatic exp_t model(input logic [NC*DW-1:0] y);
    int   v[NC];
    int   mx, n_eq;
    exp_t e;
    for (int i = 0; i < NC; i++) v[i] = int'($signed(y[i*DW +: DW]));
    mx = v[0];
    foreach (v[i]) if (v[i] > mx) mx = v[i];
    e.cls = -1;
    n_eq  = 0;
    foreach (v[i]) if (v[i] == mx) begin
      n_eq++;
      if (e.cls < 0) e.cls = i;
    end
    e.mx = mx;
`ifdef IRIS_ARGMAX_TIE_DETECT_EN
    e.tie = (n_eq > 1) ? 1 : 0;
`else
    e.tie = 0;
`endif
    return e;
  endfunction

  // Monitor: compare each newly presented result against the scoreboard head
  initial begin
    bit   seen = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!bus_if.Out_Valid) seen = 1'b0;
      else if (!seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("class",   int'(bus_if.Class), e.cls);
          chk("max_val", int'($signed(bus_if.Max_Val)), e.mx);
          chk("tie",     int'(bus_if.Tie), e.tie);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, int'(bus_if.Out_Valid), 0);
    chk({tag, "_class"},     int'(bus_if.Class), 0);
    chk({tag, "_max_val"},   int'(bus_if.Max_Val), 0);
    chk({tag, "_tie"},       int'(bus_if.Tie), 0);
    chk({tag, "_busy"},      int'(bus_if.Busy), 0);
    chk({tag, "_overrun"},   int'(bus_if.Overrun), 0);
  endtask

  // One transaction: gap = En-low cycles during COMPARE, hold = Out_Ready-low cycles after Out_Valid
  task automatic run(input logic [NC*DW-1:0] y, input int gap, input int hold, input bit inject);
    int   n;
    exp_t e;
    e = model(y);
    bus_if.Out_Ready = (hold == 0);
    @(negedge clk);
    bus_if.Y_Bus    = y;
    bus_if.In_Valid = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    bus_if.In_Valid = 1'b0;
    chk("busy_after_sample", int'(bus_if.Busy), 1);
    n = 0;
    if (gap > 0) begin
      bus_if.En = 1'b0;
      repeat (gap) begin
        @(negedge clk);
        n++;
      end
      bus_if.En = 1'b1;
    end
    while (!bus_if.Out_Valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, NC - 1 + gap);
    if (hold > 0) begin
      if (inject) begin
        bus_if.Y_Bus    = ~y;
        bus_if.In_Valid = 1'b1;
      end
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        bus_if.In_Valid = 1'b0;
        chk("held_valid", int'(bus_if.Out_Valid), 1);
        chk("held_busy",  int'(bus_if.Busy), 1);
        chk("held_class", int'(bus_if.Class), e.cls);
      end
      bus_if.Out_Ready = 1'b1;
    end
    @(negedge clk);
    chk("valid_after_accept", int'(bus_if.Out_Valid), 0);
    chk("busy_after_accept",  int'(bus_if.Busy), 0);
  endtask

  initial begin
    int y0, y1, y2;
    bus_if.En        = 1'b1;
    bus_if.In_Valid  = 1'b0;
    bus_if.Y_Bus     = '0;
    bus_if.Out_Ready = 1'b1;
    #13;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    run(pack(-3, 12, 5), 0, 0, 1'b0);
    run(pack(9, 4, 9), 0, 0, 1'b0);
    run(pack(-4, -8, -1), 0, 0, 1'b0);
    run(pack(0, 0, 0), 0, 0, 1'b0);

    chk("overrun_before", int'(bus_if.Overrun), 0);
    run(pack(7, -20, 3), 0, 5, 1'b1);
    chk("overrun_sticky", int'(bus_if.Overrun), 1);

    run(pack(1, 2, 100), 3, 0, 1'b0);

    // Abort mid-scan: result must never appear and everything clears at once
    @(negedge clk);
    bus_if.Y_Bus    = pack(50, 60, 70);
    bus_if.In_Valid = 1'b1;
    exp_q.push_back(model(bus_if.Y_Bus));
    @(negedge clk);
    bus_if.In_Valid = 1'b0;
    #2 rst = 1'b0;
    #1 check_idle_outputs("abort");
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b1;
    run(pack(-128, 127, -128), 0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        y0 = $urandom_range(0, 255);
        y1 = $urandom_range(0, 255);
        y2 = $urandom_range(0, 255);
      end else begin
        y0 = $urandom_range(0, 4) - 2;
        y1 = $urandom_range(0, 4) - 2;
        y2 = $urandom_range(0, 4) - 2;
      end
      run(pack(y0, y1, y2), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d of %0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/iris_argmax.md
# iris_argmax

Output-decision stage of the Iris network. It captures the signed outputs of the output-layer neurons when they complete their RESULT state, then scans them sequentially for the largest score. It presents the winning class index and score on a valid/ready handshake to the consumer, for example a display or UART reporter.

## Interface
- DATA_WIDTH, 8: width of each signed neuron score, same as the neuron DATA_WIDTH.
- NUM_CLASSES, 3: number of scores compared; legal range 2..16.
- CLASS_W, $clog2(NUM_CLASSES): width of the class index.

- clk  in  1  rising-edge clock, shared with the neurons.
- rst  in  1  asynchronous, active-low reset.
- En  in  1  clock enable; when low, all state and registers hold.
- In_Valid  in  1  one-cycle strobe: Y_Bus carries a complete set of neuron outputs.
- Y_Bus  in  NUM_CLASSES*DATA_WIDTH  packed signed scores; class i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- Out_Ready  in  1  consumer accepts the result.
- Out_Valid  out  1  result valid; held until accepted.
- Class  out  CLASS_W  index of the maximum score.
- Max_Val  out  DATA_WIDTH  signed maximum score.
- Tie  out  1  another class equals the maximum (see Configuration).
- Busy  out  1  high in every state except IDLE.
- Overrun  out  1  sticky; set when In_Valid arrives while Busy.

## Operation
- FSM states:
  - IDLE
    - On En && In_Valid: register all scores into YR[], set Best=YR[0], Idx=0, Cnt=1, Tie_r=0, and go to COMPARE.
  - COMPARE, one class per En cycle:
    - If YR[Cnt] > Best (signed, strict): Best=YR[Cnt], Idx=Cnt, Tie_r=0.
    - Else if YR[Cnt] == Best: Tie_r=1.
    - Cnt++.
    - When Cnt == NUM_CLASSES-1 is processed: load Class/Max_Val/Tie, set Out_Valid, and go to OUTPUT.
  - OUTPUT
    - Hold all outputs stable.
    - On En && Out_Valid && Out_Ready: clear Out_Valid and go to IDLE.
- Ties resolve to the lowest index, because replacement requires a strict >.
- In_Valid outside IDLE is dropped, and Overrun is set to 1. Overrun is cleared only by reset.
- An illegal state encoding goes to IDLE with Out_Valid=0.
- Scores are compared as full signed values; a ReLU output of 0 is legal, and all-zero inputs give Class=0.

## Timing
- Reset values: Out_Valid=0, Class=0, Max_Val=0, Tie=0, Busy=0, Overrun=0, state IDLE. YR[], Best and Cnt are cleared to 0.
- Reset asserted mid-scan or mid-handshake aborts immediately. The first clk edge after deassertion sees IDLE.
- Latency: sampling edge T → Out_Valid high after edge T+NUM_CLASSES-1 (2 cycles for 3 classes, with En held high).
- Busy is high from edge T until the accepting edge.
- Out_Ready may be high before Out_Valid. Acceptance takes effect only on an edge where both signals are high; Out_Valid is low after that edge.
- An In_Valid on the same edge as acceptance is dropped and counts as an overrun. The next set is accepted no earlier than the following edge.
- With En low, nothing advances; Out_Valid stays high and Overrun does not update.

## Configuration
- IRIS_ARGMAX_TIE_DETECT_EN
  - Defined: Tie_r logic is built, and Tie reports an equal maximum at any other index.
  - Undefined: no tie logic is built and Tie is tied to 0. Class selection is identical in both builds.

## Test plan
- Y_Bus={Y2=5, Y1=12, Y0=-3}, In_Valid at T, Out_Ready=1 → Out_Valid after T+2, Class=1, Max_Val=12, Tie=0, then Out_Valid low one edge later.
- Y={Y2=9, Y1=4, Y0=9} → Class=0, Max_Val=9; Tie=1 with the macro, Tie=0 without it.
- Y={-1,-8,-4}, all negative (Y2=-1) → Class=2, Max_Val=-1; Y={0,0,0} → Class=0, Max_Val=0.
- Out_Ready=0 for 5 cycles after Out_Valid → outputs stable and Busy=1. In_Valid during this window sets Overrun=1 and does not change Class. Raising Out_Ready → accepted, back in IDLE.
- En dropped for 3 cycles during COMPARE → latency extended by exactly 3 cycles with the same result.
- rst low during COMPARE → all outputs 0 asynchronously. A new In_Valid after release → correct result with normal latency.
